// File: rtl/video_pattern_source.sv
// Avalon-ST style RGB444 test-frame source. Emits one pixel per accepted
// transfer with startofpacket/endofpacket framing, honours ready
// backpressure and idles for a fixed gap between frames.
module video_pattern_source #(
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_LENGTH = 240,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic        ready,
  output logic        valid,
  output logic        startofpacket,
  output logic        endofpacket,
  output logic [11:0] data,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  // Colour bars need a non-zero divisor even for tiny test frames.
  localparam int unsigned BarWidth = (IMG_WIDTH / 8 == 0) ? 1 : IMG_WIDTH / 8;
  // The gap counter is loaded on the EOP edge, so it counts GAP_CYCLES-1 down to 0.
  localparam int unsigned GapLoad  = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

  localparam logic [15:0] XLast    = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] YLast    = 16'(IMG_LENGTH - 1);
  localparam logic [15:0] GapInit  = 16'(GapLoad);
  localparam logic [8:0]  BarDiv   = 9'(BarWidth);
  localparam logic        OnePixel = (IMG_WIDTH == 1) && (IMG_LENGTH == 1);

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StGap
  } state_e;

  state_e      state_q;
  logic [1:0]  pat_q;
  logic [15:0] x_q;
  logic [15:0] y_q;
  logic [15:0] gap_q;
  logic        valid_q;
  logic        sop_q;
  logic        eop_q;
  logic        done_q;
  logic [11:0] data_q;
  logic [15:0] frame_count_q;

  logic [15:0] x_nxt;
  logic [15:0] y_nxt;
  logic        last_x;
  logic        last_pix;
  logic        xfer;
  logic        start;
  logic [11:0] pix_nxt;
  logic [11:0] pix_first;

  // Pixel value as a function of pattern, 9-bit x and bit 3 of y.
  function automatic logic [11:0] pixel(input logic [1:0] pat, input logic [8:0] x,
                                        input logic y3);
    logic [2:0]  bar;
    logic [3:0]  lvl;
    logic [11:0] p;
    bar = 3'(x / BarDiv);
    lvl = x[8:5];
    case (pat)
      2'd0:    p = 12'h56A;
      2'd1:    p = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
      2'd2:    p = {lvl, lvl, lvl};
      default: p = (x[3] ^ y3) ? 12'hFFF : 12'h000;
    endcase
    return p;
  endfunction

  // Next raster position and the pixel that will be presented there.
  always_comb begin
    last_x    = (x_q == XLast);
    last_pix  = last_x && (y_q == YLast);
    x_nxt     = last_x ? 16'd0 : x_q + 16'd1;
    y_nxt     = last_x ? y_q + 16'd1 : y_q;
    xfer      = valid_q && ready;
    pix_nxt   = pixel(pat_q, x_nxt[8:0], y_nxt[3]);
    pix_first = pixel(pattern_sel, 9'd0, 1'b0);
    start     = enable && ((state_q == StIdle) || ((state_q == StGap) && (gap_q == 16'd0)));
  end

  // Frame FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      pat_q         <= 2'd0;
      x_q           <= 16'd0;
      y_q           <= 16'd0;
      gap_q         <= 16'd0;
      valid_q       <= 1'b0;
      sop_q         <= 1'b0;
      eop_q         <= 1'b0;
      done_q        <= 1'b0;
      data_q        <= 12'd0;
      frame_count_q <= 16'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle, StGap: begin
          if (start) begin
            // Pattern is sampled only here, so mid-frame changes wait for the next frame.
            pat_q   <= pattern_sel;
            x_q     <= 16'd0;
            y_q     <= 16'd0;
            data_q  <= pix_first;
            sop_q   <= 1'b1;
            eop_q   <= OnePixel;
            valid_q <= 1'b1;
            state_q <= StStream;
          end else if (state_q == StGap) begin
            if (gap_q == 16'd0) begin
              state_q <= StIdle;
            end else begin
              gap_q <= gap_q - 16'd1;
            end
          end
        end
        StStream: begin
          // Enable is not looked at here: a started frame always runs to EOP.
          if (xfer) begin
            if (last_pix) begin
              valid_q       <= 1'b0;
              sop_q         <= 1'b0;
              eop_q         <= 1'b0;
              done_q        <= 1'b1;
              frame_count_q <= frame_count_q + 16'd1;
              gap_q         <= GapInit;
              state_q       <= StGap;
            end else begin
              x_q    <= x_nxt;
              y_q    <= y_nxt;
              data_q <= pix_nxt;
              sop_q  <= 1'b0;
              eop_q  <= (x_nxt == XLast) && (y_nxt == YLast);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign valid         = valid_q;
  assign startofpacket = sop_q;
  assign endofpacket   = eop_q;
  assign data          = data_q;
  assign frame_done    = done_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_video_pattern_source.sv
// Self-checking bench for video_pattern_source. A 320x10 instance covers the
// pattern, stall and control behaviour; a 4x2 instance covers frame_count wrap.
`timescale 1ns/1ps
module tb_video_pattern_source;

  localparam int W   = 320;
  localparam int L   = 10;
  localparam int GAP = 4;
  localparam int N   = W * L;
  localparam int SW  = 4;
  localparam int SL  = 2;
  localparam int SN  = SW * SL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, enable, ready;
  logic [1:0]  pattern_sel;
  logic        valid, startofpacket, endofpacket, frame_done;
  logic [11:0] data;
  logic [15:0] frame_count;

  logic        s_reset_n, s_enable, s_ready;
  logic [1:0]  s_pattern_sel;
  logic        s_valid, s_sop, s_eop, s_frame_done;
  logic [11:0] s_data;
  logic [15:0] s_frame_count;

  int total = 0;
  int bad   = 0;

  video_pattern_source #(.IMG_WIDTH(W), .IMG_LENGTH(L), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel), .ready(ready),
    .valid(valid), .startofpacket(startofpacket), .endofpacket(endofpacket), .data(data),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  video_pattern_source #(.IMG_WIDTH(SW), .IMG_LENGTH(SL), .GAP_CYCLES(GAP)) u_small (
    .clk(clk), .reset_n(s_reset_n), .enable(s_enable), .pattern_sel(s_pattern_sel),
    .ready(s_ready), .valid(s_valid), .startofpacket(s_sop), .endofpacket(s_eop), .data(s_data),
    .frame_done(s_frame_done), .frame_count(s_frame_count)
  );

  // Reference picture for the 320-wide instance, straight from the pattern rules.
  function automatic logic [11:0] ref_pix(input int pat, input int x, input int y);
    int bar, lvl;
    logic [3:0] r, g, b;
    case (pat)
      0: return 12'h56A;
      1: begin
        bar = x / (W / 8);
        r = ((bar / 4) % 2 != 0) ? 4'hF : 4'h0;
        g = ((bar / 2) % 2 != 0) ? 4'hF : 4'h0;
        b = (bar % 2 != 0) ? 4'hF : 4'h0;
        return {r, g, b};
      end
      2: begin
        lvl = x / 32;
        return 12'(lvl * 'h111);
      end
      default: return (((x / 8) % 2) != ((y / 8) % 2)) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  task automatic apply_reset();
    reset_n = 1'b0; enable = 1'b0; ready = 1'b0; pattern_sel = 2'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", valid); end
    total++; if (startofpacket !== 1'b0) begin bad++; $display("FAIL rst_sop: got %b want 0", startofpacket); end
    total++; if (endofpacket !== 1'b0) begin bad++; $display("FAIL rst_eop: got %b want 0", endofpacket); end
    total++; if (data !== 12'h000) begin bad++; $display("FAIL rst_data: got %h want 000", data); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", frame_done); end
    total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL rst_count: got %h want 0", frame_count); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL idle_valid: got %b want 0", valid); end
    end
  endtask

  task automatic test_solid();
    int idx, gap;
    apply_reset();
    pattern_sel = 2'd0; ready = 1'b1; enable = 1'b1;
    @(negedge clk);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL solid_first_valid: got %b want 1", valid); end
    idx = 0;
    for (int cyc = 0; cyc < N + 100 && idx < N; cyc++) begin
      total++;
      if (valid !== 1'b1) begin
        bad++; $display("FAIL solid_bubble idx=%0d: got valid %b want 1", idx, valid);
      end else begin
        total++;
        if ({startofpacket, endofpacket, data} !== {idx == 0, idx == N - 1, 12'h56A}) begin
          bad++;
          $display("FAIL solid_pix idx=%0d: got sop=%b eop=%b data=%h want sop=%b eop=%b data=56a",
                   idx, startofpacket, endofpacket, data, idx == 0, idx == N - 1);
        end
        idx++;
      end
      @(negedge clk);
    end
    total++; if (idx != N) begin bad++; $display("FAIL solid_count: got %0d want %0d", idx, N); end
    total++;
    if ({valid, frame_done, frame_count} !== {1'b0, 1'b1, 16'd1}) begin
      bad++; $display("FAIL solid_after_eop: got valid=%b done=%b count=%0d want 0 1 1",
                      valid, frame_done, frame_count);
    end
    gap = 0;
    for (int cyc = 0; cyc < 20 && valid !== 1'b1; cyc++) begin
      gap++;
      @(negedge clk);
    end
    total++; if (gap != GAP) begin bad++; $display("FAIL solid_gap: got %0d want %0d", gap, GAP); end
    total++;
    if ({startofpacket, data, frame_done} !== {1'b1, 12'h56A, 1'b0}) begin
      bad++; $display("FAIL solid_next_sop: got sop=%b data=%h done=%b want 1 56a 0",
                      startofpacket, data, frame_done);
    end
    enable = 1'b0;
  endtask

  task automatic test_bars();
    int idx, x, y;
    bit spot;
    logic [11:0] want;
    apply_reset();
    pattern_sel = 2'd1; ready = 1'b1; enable = 1'b1;
    @(negedge clk);
    idx = 0;
    for (int cyc = 0; cyc < N + 100 && idx < N; cyc++) begin
      x = idx % W; y = idx / W;
      total++;
      if ({valid, startofpacket, endofpacket, data} !==
          {1'b1, idx == 0, idx == N - 1, ref_pix(1, x, y)}) begin
        bad++; $display("FAIL bars_pix x=%0d y=%0d: got v=%b data=%h want v=1 data=%h",
                        x, y, valid, data, ref_pix(1, x, y));
      end
      spot = 1'b1; want = 12'h000;
      case (x)
        0, 39:    want = 12'h000;
        40:       want = 12'h00F;
        279:      want = 12'hFF0;
        280, 319: want = 12'hFFF;
        default:  spot = 1'b0;
      endcase
      if (spot) begin
        total++;
        if (data !== want) begin
          bad++; $display("FAIL bars_spot x=%0d y=%0d: got %h want %h", x, y, data, want);
        end
      end
      if (valid === 1'b1) idx++;
      @(negedge clk);
    end
    total++; if (idx != N) begin bad++; $display("FAIL bars_count: got %0d want %0d", idx, N); end
    enable = 1'b0;
  endtask

  task automatic test_checker();
    int idx, x, y, stall_left, stall_idx;
    apply_reset();
    pattern_sel = 2'd3; enable = 1'b1; ready = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    idx = 0; stall_left = 0; stall_idx = -1;
    for (int cyc = 0; cyc < 8 * N && idx < N; cyc++) begin
      x = idx % W; y = idx / W;
      if (x % 15 == 0 && stall_idx != idx) begin
        stall_left = 5; stall_idx = idx;
      end
      if (stall_left > 0) begin
        ready = 1'b0; stall_left--;
      end else begin
        ready = ($urandom_range(0, 3) != 0);
      end
      // The presented pixel must be pixel idx whether or not it is being stalled.
      total++;
      if ({valid, startofpacket, endofpacket, data} !==
          {1'b1, idx == 0, idx == N - 1, ref_pix(3, x, y)}) begin
        bad++; $display("FAIL chk_pix idx=%0d: got v=%b sop=%b eop=%b data=%h want data=%h",
                        idx, valid, startofpacket, endofpacket, data, ref_pix(3, x, y));
      end
      if (x == 8 && y == 0) begin
        total++; if (data !== 12'hFFF) begin bad++; $display("FAIL chk_8_0: got %h want fff", data); end
      end
      if (x == 8 && y == 8) begin
        total++; if (data !== 12'h000) begin bad++; $display("FAIL chk_8_8: got %h want 000", data); end
      end
      if (valid === 1'b1 && ready) idx++;
      @(negedge clk);
    end
    ready = 1'b1;
    total++; if (idx != N) begin bad++; $display("FAIL chk_count: got %0d want %0d", idx, N); end
    total++;
    if ({valid, frame_done, frame_count} !== {1'b0, 1'b1, 16'd1}) begin
      bad++; $display("FAIL chk_end: got valid=%b done=%b count=%0d want 0 1 1",
                      valid, frame_done, frame_count);
    end
  endtask

  task automatic test_enable_drop();
    int idx, x, y, pulses;
    apply_reset();
    pattern_sel = 2'd0; ready = 1'b1; enable = 1'b1;
    @(negedge clk);
    idx = 0;
    for (int cyc = 0; cyc < N + 100 && idx < N; cyc++) begin
      if (idx == 1000) begin
        enable = 1'b0; pattern_sel = 2'd2;
      end
      total++;
      if ({valid, startofpacket, endofpacket, data} !== {1'b1, idx == 0, idx == N - 1, 12'h56A}) begin
        bad++; $display("FAIL drop_pix idx=%0d: got v=%b sop=%b eop=%b data=%h want data=56a",
                        idx, valid, startofpacket, endofpacket, data);
      end
      if (valid === 1'b1) idx++;
      @(negedge clk);
    end
    total++; if (idx != N) begin bad++; $display("FAIL drop_count: got %0d want %0d", idx, N); end
    pulses = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (frame_done === 1'b1) pulses++;
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL drop_idle cyc=%0d: got valid %b want 0", cyc, valid); end
      @(negedge clk);
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL drop_done_pulses: got %0d want 1", pulses); end
    total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL drop_fcount: got %0d want 1", frame_count); end
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < N + 100 && idx < N; cyc++) begin
      x = idx % W; y = idx / W;
      total++;
      if ({valid, startofpacket, data} !== {1'b1, idx == 0, ref_pix(2, x, y)}) begin
        bad++; $display("FAIL grad_pix x=%0d y=%0d: got v=%b sop=%b data=%h want data=%h",
                        x, y, valid, startofpacket, data, ref_pix(2, x, y));
      end
      if (x == 319) begin
        total++; if (data !== 12'h999) begin bad++; $display("FAIL grad_319: got %h want 999", data); end
      end
      if (valid === 1'b1) idx++;
      @(negedge clk);
    end
    total++; if (idx != N) begin bad++; $display("FAIL grad_count: got %0d want %0d", idx, N); end
  endtask

  task automatic test_reset_mid();
    int acc;
    bit stopped, seen;
    apply_reset();
    pattern_sel = 2'd0; ready = 1'b1; enable = 1'b1;
    acc = 0; stopped = 1'b0;
    for (int cyc = 0; cyc < 2 * N + 100 && !stopped; cyc++) begin
      @(negedge clk);
      if (valid === 1'b1 && acc == N + 500) begin
        ready = 1'b0; stopped = 1'b1;
      end else if (valid === 1'b1) begin
        acc++;
      end
    end
    total++; if (stopped != 1'b1) begin bad++; $display("FAIL rmid_reach: got acc=%0d want %0d", acc, N + 500); end
    @(negedge clk);
    total++;
    if ({valid, startofpacket, data, frame_count} !== {1'b1, 1'b0, 12'h56A, 16'd1}) begin
      bad++; $display("FAIL rmid_hold: got v=%b sop=%b data=%h count=%0d want 1 0 56a 1",
                      valid, startofpacket, data, frame_count);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({valid, startofpacket, endofpacket, data, frame_done, frame_count} !== 32'd0) begin
      bad++; $display("FAIL rmid_async: got v=%b sop=%b eop=%b data=%h done=%b count=%0d want all 0",
                      valid, startofpacket, endofpacket, data, frame_done, frame_count);
    end
    @(negedge clk);
    reset_n = 1'b1; ready = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge clk);
      if (valid === 1'b1) seen = 1'b1;
    end
    total++;
    if ({seen, startofpacket, endofpacket, data, frame_count} !== {1'b1, 1'b1, 1'b0, 12'h56A, 16'd0}) begin
      bad++; $display("FAIL rmid_restart: got seen=%b sop=%b eop=%b data=%h count=%0d want 1 1 0 56a 0",
                      seen, startofpacket, endofpacket, data, frame_count);
    end
    enable = 1'b0;
  endtask

  task automatic test_wrap();
    logic [15:0] exp_fc;
    int idx, frames;
    bit prev_acc, acc;
    s_reset_n = 1'b0; s_enable = 1'b0; s_ready = 1'b0; s_pattern_sel = 2'd0;
    repeat (2) @(negedge clk);
    s_reset_n = 1'b1;
    @(negedge clk);
    force u_small.frame_count_q = 16'hFFFD;
    @(negedge clk);
    release u_small.frame_count_q;
    @(negedge clk);
    total++; if (s_frame_count !== 16'hFFFD) begin bad++; $display("FAIL wrap_preload: got %h want fffd", s_frame_count); end
    exp_fc = 16'hFFFD; idx = 0; frames = 0; prev_acc = 1'b0;
    s_enable = 1'b1;
    for (int cyc = 0; cyc < 400 && frames < 4; cyc++) begin
      @(negedge clk);
      if (prev_acc) begin
        exp_fc = exp_fc + 16'd1;
        frames++;
      end
      total++;
      if ({s_frame_done, s_frame_count} !== {prev_acc, exp_fc}) begin
        bad++; $display("FAIL wrap_count cyc=%0d: got done=%b count=%h want done=%b count=%h",
                        cyc, s_frame_done, s_frame_count, prev_acc, exp_fc);
      end
      if (idx != 0) begin
        total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL wrap_hold idx=%0d: got valid %b want 1", idx, s_valid); end
      end
      s_ready = ($urandom_range(0, 2) != 0);
      acc = (s_valid === 1'b1) && s_ready;
      if (s_valid === 1'b1) begin
        total++;
        if ({s_sop, s_eop, s_data} !== {idx == 0, idx == SN - 1, 12'h56A}) begin
          bad++; $display("FAIL wrap_pix idx=%0d: got sop=%b eop=%b data=%h want sop=%b eop=%b data=56a",
                          idx, s_sop, s_eop, s_data, idx == 0, idx == SN - 1);
        end
      end
      prev_acc = acc && (idx == SN - 1);
      if (acc) idx = (idx + 1) % SN;
    end
    total++; if (frames != 4) begin bad++; $display("FAIL wrap_frames: got %0d want 4", frames); end
    s_enable = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; ready = 1'b0; pattern_sel = 2'd0;
    s_reset_n = 1'b0; s_enable = 1'b0; s_ready = 1'b0; s_pattern_sel = 2'd0;
    test_reset();
    test_solid();
    test_bars();
    test_checker();
    test_enable_drop();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
